// File: rtl/uart_frame_tx.sv
// Packet framer feeding an 8N1 UART byte transmitter: buffers up to DEPTH payload
// bytes, then sends SYNC, LEN, payload, CHK over the tx_data/tx_start/tx_busy handshake.
module uart_frame_tx #(
  parameter int         DEPTH = 16,
  parameter int         AW    = 4,
  parameter logic [7:0] SYNC  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       frame_busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {S_FILL, S_SYNC, S_LEN, S_PAY, S_CHK} state_t;
  typedef enum logic [1:0] {P_ISSUE, P_GAP, P_WAIT} phase_t;

  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  function automatic logic [7:0] len_byte(input logic [AW:0] c);
    return 8'(c);
  endfunction

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   pend_q, pend_d;
  logic [7:0]    chk_q, chk_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          done_q, done_d;
  logic          ready_en_q, ready_en_d;
  logic          accept;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_byte;

  assign in_ready   = (state_q == S_FILL) && ready_en_q;
  assign accept     = in_valid && in_ready;
  assign rd_byte    = mem[rd_ptr_q];
  assign tx_data    = tx_data_q;
  assign tx_start   = (state_q != S_FILL) && (phase_q == P_ISSUE) && !tx_busy;
  assign frame_busy = (state_q != S_FILL);
  assign frame_done = done_q;

  // Payload storage carries no reset; occupancy is tracked by cnt and the pointers.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= in_data;
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    chk_d      = chk_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_data_d  = tx_data_q;
    done_d     = 1'b0;
    ready_en_d = 1'b1;

    if (state_q == S_FILL) begin
      if (accept) begin
        cnt_d    = cnt_q + 1'b1;
        chk_d    = chk_q ^ in_data;
        wr_ptr_d = wr_ptr_q + 1'b1;
        // The DEPTH-th byte closes the frame regardless of in_last.
        if (in_last || (cnt_q == CNT_LAST)) begin
          state_d   = S_SYNC;
          phase_d   = P_ISSUE;
          tx_data_d = SYNC;
        end
      end
    end else begin
      unique case (phase_q)
        P_ISSUE: if (!tx_busy) phase_d = P_GAP;
        // One idle cycle lets the transmitter raise tx_busy before it is watched.
        P_GAP:   phase_d = P_WAIT;
        P_WAIT: begin
          if (!tx_busy) begin
            phase_d = P_ISSUE;
            unique case (state_q)
              S_SYNC: begin
                state_d   = S_LEN;
                tx_data_d = len_byte(cnt_q);
                chk_d     = chk_q ^ len_byte(cnt_q);
                pend_d    = cnt_q;
              end
              S_LEN, S_PAY: begin
                if (pend_q != '0) begin
                  state_d   = S_PAY;
                  tx_data_d = rd_byte;
                  rd_ptr_d  = rd_ptr_q + 1'b1;
                  pend_d    = pend_q - 1'b1;
                end else begin
                  state_d   = S_CHK;
                  tx_data_d = chk_q;
                end
              end
              S_CHK: begin
                state_d    = S_FILL;
                cnt_d      = '0;
                pend_d     = '0;
                chk_d      = '0;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                done_d     = 1'b1;
                ready_en_d = 1'b0;
              end
              default: state_d = S_FILL;
            endcase
          end
        end
        default: phase_d = P_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      phase_q    <= P_ISSUE;
      cnt_q      <= '0;
      pend_q     <= '0;
      chk_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      chk_q      <= chk_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
      ready_en_q <= ready_en_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx with a simple busy-for-N-cycles UART model.
module tb_uart_frame_tx;

  localparam int BUSY_LEN = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       frame_busy;
  logic       frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;
  int n_starts = 0;
  int done_cnt = 0;
  time done_t = 0;
  time acc_t  = 0;
  logic force_busy = 1'b0;
  logic [7:0] sent[$];
  logic [7:0] exp_q[$];

  uart_frame_tx #(.DEPTH(16), .AW(4), .SYNC(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .frame_busy(frame_busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART model and bus monitor: samples mid-cycle, updates tx_busy just after the edge.
  initial begin
    int   left;
    logic st;
    logic prev_st;
    left    = 0;
    prev_st = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      st = tx_start;
      if (st) begin
        sent.push_back(tx_data);
        n_starts++;
        if (tx_busy || prev_st) viol++;
      end
      if (frame_done) begin
        done_cnt++;
        done_t = $time;
      end
      prev_st = st;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        left    = 0;
        tx_busy = 1'b0;
      end else if (st) begin
        left    = BUSY_LEN;
        tx_busy = 1'b1;
      end else if (left > 0) begin
        left--;
        tx_busy = (left != 0) || force_busy;
      end else begin
        tx_busy = force_busy;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic push(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("push_wait", in_ready, 1'b1);
    acc_t = $time;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!frame_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check(tag, frame_done, 1'b1);
  endtask

  task automatic cmp_frame(input string tag);
    check({tag, "_len"}, sent.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(sent[i]), 32'(exp_q[i]));
    sent.delete();
    exp_q.delete();
  endtask

  initial begin
    int s0;
    int d0;
    int hi;
    rst_n    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #3;
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_frame_busy", frame_busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rel_in_ready_lo", in_ready, 1'b0);
    @(negedge clk);
    check("rel_in_ready_hi", in_ready, 1'b1);

    // Three-byte frame
    s0 = n_starts;
    d0 = done_cnt;
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b1);
    check("t1_latency_start", tx_start, 1'b1);
    check("t1_frame_busy", frame_busy, 1'b1);
    wait_done("t1_done");
    @(negedge clk);
    check("t1_starts", n_starts - s0, 6);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_frame_busy_end", frame_busy, 1'b0);
    exp_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    cmp_frame("t1");

    // Single byte, in_ready window
    push(8'h5A, 1'b1);
    check("t2_ready_after_acc", in_ready, 1'b0);
    hi = 0;
    while (!frame_done && hi < 3000) begin
      if (in_ready) hi += 10000;
      @(negedge clk);
      hi++;
    end
    check("t2_ready_stayed_low", (hi >= 3000) ? 1 : 0, 0);
    check("t2_done_ready", in_ready, 1'b0);
    check("t2_done_busy", frame_busy, 1'b0);
    @(negedge clk);
    check("t2_ready_after_done", in_ready, 1'b1);
    exp_q = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
    cmp_frame("t2");

    // Forced close at DEPTH bytes, 17th byte stalls into the next frame
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    check("t3_ready_after_full", in_ready, 1'b0);
    check("t3_latency_start", tx_start, 1'b1);
    push(8'h77, 1'b1);
    check("t3_17th_after_done", done_cnt - d0, 1);
    wait_done("t3_done2");
    @(negedge clk);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h10);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h10);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h76);
    cmp_frame("t3");

    // Foreign traffic holds tx_busy at frame close
    force_busy = 1'b1;
    @(negedge clk);
    push(8'h3C, 1'b1);
    check("t4_no_start_busy", tx_start, 1'b0);
    check("t4_frame_busy", frame_busy, 1'b1);
    s0 = n_starts;
    repeat (50) @(negedge clk);
    check("t4_stalled", n_starts - s0, 0);
    force_busy = 1'b0;
    @(negedge clk);
    check("t4_start_on_release", tx_start, 1'b1);
    wait_done("t4_done");
    @(negedge clk);
    exp_q = '{8'hA5, 8'h01, 8'h3C, 8'h3D};
    cmp_frame("t4");

    // Back-to-back frames with in_valid held high
    push(8'hC1, 1'b0);
    push(8'hC2, 1'b1);
    push(8'hD1, 1'b0);
    check("t6_accept_after_done", 32'(acc_t - done_t), 10);
    push(8'hD2, 1'b1);
    wait_done("t6_done");
    @(negedge clk);
    exp_q = '{8'hA5, 8'h02, 8'hC1, 8'hC2, 8'h01, 8'hA5, 8'h02, 8'hD1, 8'hD2, 8'h01};
    cmp_frame("t6");

    // Reset in the middle of the payload
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    push(8'h04, 1'b1);
    hi = 0;
    while (sent.size() < 4 && hi < 1000) begin
      @(negedge clk);
      hi++;
    end
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx_data", tx_data, 8'h00);
    check("t5_rst_tx_start", tx_start, 1'b0);
    check("t5_rst_frame_busy", frame_busy, 1'b0);
    check("t5_rst_frame_done", frame_done, 1'b0);
    check("t5_rst_in_ready", in_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_ready_after_rel", in_ready, 1'b1);
    check("t5_partial_bytes", sent.size(), 4);
    sent.delete();
    push(8'hFF, 1'b1);
    wait_done("t5_done");
    @(negedge clk);
    exp_q = '{8'hA5, 8'h01, 8'hFF, 8'hFE};
    cmp_frame("t5");

    check("start_protocol_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
